// File: rtl/rf16x160_pkg.sv
// rf16x160_pkg: constants and the read-FSM state type shared by the
// 16 x 160 register-file queue controller and its sub-modules.
package rf16x160_pkg;

  localparam int RF_DW = 160;
  localparam int RF_AW = 4;
  localparam int RF_NW = 4;
  localparam int RF_BW = RF_DW / 8;

  // Byte enables are not used for partial writes; every byte is always enabled
  localparam logic [RF_BW-1:0] RF_BYTE_WEN_ALL = {RF_BW{1'b1}};

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_HOLD  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rf_q_rr_arb2.sv
// rf_q_rr_arb2: two-requester round-robin arbiter for the shared write port.
// rr_last_q is set when producer 0 won the most recent grant, so its reset
// value of 0 leaves producer 0 with first priority.
module rf_q_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic vld0,
  input  logic vld1,
  output logic gnt0,
  output logic gnt1
);

  logic rr_last_q;
  logic rr_last_d;

  // Pick a winner; a contended cycle goes to the producer that did not win last
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (vld0 && vld1) begin
        if (rr_last_q) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = vld0;
        gnt1 = vld1;
      end
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Every grant, contended or not, moves priority to the other producer
  always_comb begin
    if (gnt0) begin
      rr_last_d = 1'b1;
    end else if (gnt1) begin
      rr_last_d = 1'b0;
    end else begin
      rr_last_d = rr_last_q;
    end
  end

  // Priority state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_q <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/rf16x160_q_ctl.sv
// rf16x160_q_ctl: runs the 16 x 160 R1W1 register-file macro as a shared FIFO.
// Two producers share the write port through a round-robin arbiter; a single
// consumer drains through a registered valid/ready interface. Entries become
// visible to the reader two cycles after their grant so a read never hits the
// macro's pending write to the same address.
// Optional: define RF16X160_Q_CTL_WMARK_EN to add WMARK and the q_afull output.
module rf16x160_q_ctl
  import rf16x160_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW,
  parameter int NW = RF_NW
`ifdef RF16X160_Q_CTL_WMARK_EN
  ,
  parameter int WMARK = 12
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_vld,
  input  logic [DW-1:0]   req0_data,
  input  logic [NW-1:0]   req0_wmask,
  output logic            req0_gnt,
  input  logic            req1_vld,
  input  logic [DW-1:0]   req1_data,
  input  logic [NW-1:0]   req1_wmask,
  output logic            req1_gnt,
  output logic            q_full,
  output logic [AW:0]     q_cnt,
`ifdef RF16X160_Q_CTL_WMARK_EN
  output logic            q_afull,
`endif
  output logic            deq_vld,
  output logic [DW-1:0]   deq_data,
  input  logic            deq_rdy,
  output logic            rf_wr_en,
  output logic [AW-1:0]   rf_wr_adr,
  output logic [NW-1:0]   rf_word_wen,
  output logic [DW/8-1:0] rf_byte_wen,
  output logic [DW-1:0]   rf_din,
  output logic            rf_read_en,
  output logic [AW-1:0]   rf_rd_adr,
  input  logic [DW-1:0]   rf_dout
);

  localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};

  rd_state_e       state_q;
  rd_state_e       state_d;
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   wptr_d;
  logic [AW-1:0]   rptr_q;
  logic [AW-1:0]   rptr_d;
  logic [AW:0]     q_cnt_q;
  logic [AW:0]     q_cnt_d;
  logic [AW:0]     vis_cnt_q;
  logic [AW:0]     vis_cnt_d;
  logic            wr_pipe_q;
  logic            wr_pipe_d;
  logic            deq_vld_q;
  logic            deq_vld_d;
  logic [DW-1:0]   deq_data_q;
  logic [DW-1:0]   deq_data_d;

  logic            gnt0_s;
  logic            gnt1_s;
  logic            gnt_any_s;
  logic            arb_en_s;
  logic            q_full_s;
  logic            hs_s;
  logic            vis_any_s;
  logic            fetch_s;
  logic            rd_issue_s;

  // A full queue blocks both producers, even in a cycle that frees an entry
  assign q_full_s  = (q_cnt_q == CNT_FULL);
  assign arb_en_s  = ~q_full_s & ~reset;
  assign gnt_any_s = gnt0_s | gnt1_s;
  assign hs_s      = deq_vld_q & deq_rdy;
  assign vis_any_s = (vis_cnt_q != CNT_ZERO);

  rf_q_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en_s),
    .vld0  (req0_vld),
    .vld1  (req1_vld),
    .gnt0  (gnt0_s),
    .gnt1  (gnt1_s)
  );

  // Steer the granted producer onto the macro write port in the grant cycle
  always_comb begin
    rf_wr_en    = gnt_any_s;
    rf_wr_adr   = wptr_q;
    rf_din      = {DW{1'b0}};
    rf_word_wen = {NW{1'b0}};
    if (gnt0_s) begin
      rf_din      = req0_data;
      rf_word_wen = req0_wmask;
    end else if (gnt1_s) begin
      rf_din      = req1_data;
      rf_word_wen = req1_wmask;
    end else begin
      rf_din      = {DW{1'b0}};
      rf_word_wen = {NW{1'b0}};
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next state: one fetch per visible entry, held until accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: begin
        if (vis_any_s) begin
          state_d = RD_FETCH;
        end else begin
          state_d = RD_IDLE;
        end
      end
      RD_FETCH: begin
        state_d = RD_HOLD;
      end
      RD_HOLD: begin
        if (hs_s) begin
          if (vis_any_s) begin
            state_d = RD_FETCH;
          end else begin
            state_d = RD_IDLE;
          end
        end else begin
          state_d = RD_HOLD;
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  // Read FSM outputs: read strobe, and the cycle the macro output is valid
  always_comb begin
    rd_issue_s = 1'b0;
    fetch_s    = 1'b0;
    case (state_q)
      RD_IDLE:  rd_issue_s = vis_any_s;
      RD_FETCH: fetch_s    = 1'b1;
      RD_HOLD:  rd_issue_s = hs_s & vis_any_s;
      default: begin
        rd_issue_s = 1'b0;
        fetch_s    = 1'b0;
      end
    endcase
  end

  // Next values for pointers, counters and the dequeue register
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    deq_vld_d  = deq_vld_q;
    deq_data_d = deq_data_q;
    if (gnt_any_s) begin
      wptr_d = wptr_q + AW'(1'b1);
    end else begin
      wptr_d = wptr_q;
    end
    if (fetch_s) begin
      deq_vld_d  = 1'b1;
      deq_data_d = rf_dout;
      rptr_d     = rptr_q + AW'(1'b1);
    end else if (hs_s) begin
      deq_vld_d  = 1'b0;
    end else begin
      deq_vld_d  = deq_vld_q;
    end
    // Grant pipeline: stage one is wr_pipe_q, stage two lands in vis_cnt_q
    wr_pipe_d = gnt_any_s;
    vis_cnt_d = vis_cnt_q + (AW+1)'(wr_pipe_q) - (AW+1)'(fetch_s);
    q_cnt_d   = q_cnt_q + (AW+1)'(gnt_any_s) - (AW+1)'(hs_s);
  end

  // Queue bookkeeping and dequeue output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q     <= {AW{1'b0}};
      rptr_q     <= {AW{1'b0}};
      q_cnt_q    <= CNT_ZERO;
      vis_cnt_q  <= CNT_ZERO;
      wr_pipe_q  <= 1'b0;
      deq_vld_q  <= 1'b0;
      deq_data_q <= {DW{1'b0}};
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      q_cnt_q    <= q_cnt_d;
      vis_cnt_q  <= vis_cnt_d;
      wr_pipe_q  <= wr_pipe_d;
      deq_vld_q  <= deq_vld_d;
      deq_data_q <= deq_data_d;
    end
  end

`ifdef RF16X160_Q_CTL_WMARK_EN
  logic q_afull_q;
  logic q_afull_d;

  // Almost-full follows the occupancy being loaded on this edge
  always_comb begin
    q_afull_d = (q_cnt_d >= (AW+1)'(WMARK));
  end

  // Almost-full output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_afull_q <= 1'b0;
    end else begin
      q_afull_q <= q_afull_d;
    end
  end

  assign q_afull = q_afull_q;
`endif

  assign req0_gnt    = gnt0_s;
  assign req1_gnt    = gnt1_s;
  assign q_full      = q_full_s;
  assign q_cnt       = q_cnt_q;
  assign deq_vld     = deq_vld_q;
  assign deq_data    = deq_data_q;
  assign rf_byte_wen = RF_BYTE_WEN_ALL;
  assign rf_read_en  = rd_issue_s;
  assign rf_rd_adr   = rptr_q;

endmodule
